// File: rtl/mont_exp_ctrl.sv
// Modular exponentiation sequencer: pre-scales the base into the Montgomery domain,
// then runs right-to-left square-and-multiply on one shared Montgomery product unit.
module mont_exp_ctrl #(
  parameter int WIDTH    = 256,
  parameter int EXP_BITS = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_a_pow_d,
  output logic             o_finished,
  output logic             o_ma_start,
  output logic [WIDTH-1:0] o_ma_a,
  output logic [WIDTH-1:0] o_ma_b,
  output logic [WIDTH-1:0] o_ma_n,
  input  logic [WIDTH-1:0] i_ma_result,
  input  logic             i_ma_end
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE, PREP, MUL_GO, MUL_WAIT, SQR_GO, SQR_WAIT, DRAIN, DONE
  } state_t;

  state_t           state_q, state_d, ret_q, ret_d;
  logic [WIDTH-1:0] m_q, m_d, t_q, t_d, d_q, d_d, n_q, n_d, res_q, res_d;
  logic [CW-1:0]    idx_q, idx_d, k_q, k_d;
  logic [WIDTH:0]   dbl;
  logic             dbl_ge;

  // t < n, so 2t < 2n and a single conditional subtract keeps t reduced
  assign dbl    = {t_q, 1'b0};
  assign dbl_ge = (dbl >= {1'b0, n_q});

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    m_d        = m_q;
    t_d        = t_q;
    d_d        = d_q;
    n_d        = n_q;
    res_d      = res_q;
    idx_d      = idx_q;
    k_d        = k_q;
    o_ma_start = 1'b0;
    o_finished = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          d_d     = i_d;
          n_d     = i_n;
          t_d     = i_a;
          m_d     = WIDTH'(1);
          k_d     = '0;
          idx_d   = '0;
          state_d = PREP;
        end
      end
      PREP: begin
        t_d = dbl_ge ? (dbl[WIDTH-1:0] - n_q) : dbl[WIDTH-1:0];
        k_d = k_q + 1'b1;
        if (k_q == CW'(WIDTH-1)) state_d = d_q[0] ? MUL_GO : SQR_GO;
      end
      MUL_GO: begin
        o_ma_start = 1'b1;
        state_d    = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (i_ma_end) begin
          m_d     = i_ma_result;
          ret_d   = SQR_GO;
          state_d = DRAIN;
        end
      end
      SQR_GO: begin
        o_ma_start = 1'b1;
        state_d    = SQR_WAIT;
      end
      SQR_WAIT: begin
        if (i_ma_end) begin
          t_d   = i_ma_result;
          idx_d = idx_q + 1'b1;
          // the final square is issued even though its result is never used
          if (idx_q == CW'(EXP_BITS-1)) ret_d = DONE;
          else                          ret_d = d_q[idx_q + 1'b1] ? MUL_GO : SQR_GO;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!i_ma_end) begin
          state_d = ret_q;
          if (ret_q == DONE) res_d = m_q;
        end
      end
      DONE: begin
        o_finished = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      m_q     <= '0;
      t_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      m_q     <= m_d;
      t_q     <= t_d;
      d_q     <= d_d;
      n_q     <= n_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
    end
  end

  // m stays plain, t stays Montgomery-scaled: MA(m, t) yields a plain product
  assign o_ma_a    = (state_q == MUL_GO || state_q == MUL_WAIT) ? m_q : t_q;
  assign o_ma_b    = t_q;
  assign o_ma_n    = n_q;
  assign o_a_pow_d = res_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural Montgomery unit with random latency,
// golden modexp scoreboard, protocol monitors on the start/end handshake.
module tb_mont_exp_ctrl;
  localparam int W = 256;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] a = '0, d = '0, n = '0;
  logic [W-1:0] res, ma_a, ma_b, ma_n;
  logic         fin, ma_start;
  logic [W-1:0] ma_res = '0;
  logic         ma_end = 1'b0;

  mont_exp_ctrl #(.WIDTH(W), .EXP_BITS(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_d(d), .i_n(n),
    .o_a_pow_d(res), .o_finished(fin), .o_ma_start(ma_start),
    .o_ma_a(ma_a), .o_ma_b(ma_b), .o_ma_n(ma_n),
    .i_ma_result(ma_res), .i_ma_end(ma_end)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int st_cnt = 0, fin_cnt = 0, viol = 0, fixed_lat = 0;
  logic [W-1:0] q[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mont(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [W-1:0] m);
    logic [W+1:0] s;
    s = '0;
    for (int k = 0; k < W; k++) begin
      if (x[k]) s = s + {2'b0, y};
      if (s[0]) s = s + {2'b0, m};
      s = s >> 1;
    end
    if (s >= {2'b0, m}) s = s - {2'b0, m};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] m);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    p = p % {{W{1'b0}}, m};
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] m);
    logic [W-1:0] r, x;
    r = W'(1);
    x = b;
    for (int k = 0; k < W; k++) begin
      if (e[k]) r = mulmod(r, x, m);
      x = mulmod(x, x, m);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] v;
    for (int k = 0; k < W/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Montgomery unit model: result valid only in first end cycle, zero in the second
  bit           mbusy = 1'b0, prev_start = 1'b0, prev_fin = 1'b0;
  int           cnt = 0, phase = 0;
  logic [W-1:0] ca, cb, cn;

  always @(negedge clk) begin
    if (rst) begin
      mbusy = 1'b0; phase = 0; ma_end = 1'b0; ma_res = '0; prev_start = 1'b0;
    end else begin
      if (ma_start) begin
        st_cnt++;
        if (prev_start || ma_end || mbusy) viol++;
      end
      prev_start = ma_start;
      if (phase == 2) begin
        ma_end = 1'b0; phase = 0; mbusy = 1'b0;
      end else if (phase == 1) begin
        ma_res = '0; phase = 2;
      end else if (mbusy) begin
        if (ma_a !== ca || ma_b !== cb || ma_n !== cn) viol++;
        cnt--;
        if (cnt == 0) begin
          ma_end = 1'b1; ma_res = mont(ca, cb, cn); phase = 1;
        end
      end else if (ma_start) begin
        ca = ma_a; cb = ma_b; cn = ma_n; mbusy = 1'b1;
        if (fixed_lat > 0)                    cnt = fixed_lat;
        else if ($urandom_range(0, 15) == 0)  cnt = $urandom_range(1, 40);
        else                                  cnt = $urandom_range(1, 2);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (fin) begin
        fin_cnt++;
        if (prev_fin) viol++;
        if (q.size() == 0) chk("unexpected_fin", W'(1), W'(0));
        else               chk("result", res, q.pop_front());
      end
      prev_fin = fin;
    end else prev_fin = 1'b0;
  end

  task automatic wait_fin(input int f0, input string tag);
    int c = 0;
    while (fin_cnt == f0 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_timeout"}, W'(fin_cnt != f0), W'(1));
  endtask

  task automatic run(input logic [W-1:0] aa, input logic [W-1:0] dd, input logic [W-1:0] nn,
                     input logic [W-1:0] expv, output int starts);
    int s0, f0;
    @(negedge clk);
    a = aa; d = dd; n = nn; start = 1'b1;
    q.push_back(expv);
    s0 = st_cnt; f0 = fin_cnt;
    @(negedge clk);
    start = 1'b0;
    wait_fin(f0, "run");
    repeat (3) @(negedge clk);
    chk("fin_pulses", W'(fin_cnt - f0), W'(1));
    starts = st_cnt - s0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_res"},   res,        '0);
    chk({tag, "_fin"},   W'(fin),    '0);
    chk({tag, "_start"}, W'(ma_start), '0);
    chk({tag, "_ma_a"},  ma_a,       '0);
    chk({tag, "_ma_b"},  ma_b,       '0);
    chk({tag, "_ma_n"},  ma_n,       '0);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: run exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s0, f0, c;
    logic [W-1:0] ra, rd, rn, ev;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    run(W'(3), W'(5), W'(13), W'(9), s);
    chk("t1_starts", W'(s), W'(258));
    run(W'('h1234), W'(0), W'('hFFFF_FFFB), W'(1), s);
    chk("t2_starts", W'(s), W'(256));
    run(W'(0), W'(7), W'('h10001), W'(0), s);
    run(W'(2), W'('h10), W'('h3F1), W'(960), s);

    for (int v = 0; v < 20; v++) begin
      rn = rand256() | W'(1);
      if (rn == W'(1)) rn = W'(3);
      ra = rand256() % rn;
      rd = rand256();
      run(ra, rd, rn, modexp(ra, rd, rn), s);
      chk("rnd_starts", W'(s), W'(W + $countones(rd)));
    end

    // start held high and operands scrambled while the run is in flight
    @(negedge clk);
    a = W'(5); d = W'(17); n = W'(101); start = 1'b1;
    q.push_back(modexp(W'(5), W'(17), W'(101)));
    f0 = fin_cnt; c = 0;
    while (fin_cnt == f0 && c < 20000) begin
      @(negedge clk);
      a = rand256(); d = rand256(); c++;
    end
    start = 1'b0;
    chk("hold_timeout", W'(fin_cnt != f0), W'(1));
    ev = modexp(W'(7), W'('h1F), W'('h3F1));
    run(W'(7), W'('h1F), W'('h3F1), ev, s);

    // reset while the first multiply is outstanding
    fixed_lat = 40;
    @(negedge clk);
    a = W'(3); d = W'(5); n = W'(13); start = 1'b1;
    q.push_back(W'(9));
    s0 = st_cnt; f0 = fin_cnt;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (st_cnt == s0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("rst_first_call", W'(st_cnt != s0), W'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    q.delete();
    rst = 1'b0;
    s0 = st_cnt;
    repeat (60) @(negedge clk);
    chk("midrst_no_fin",   W'(fin_cnt), W'(f0));
    chk("midrst_no_start", W'(st_cnt),  W'(s0));
    fixed_lat = 0;
    run(W'(3), W'(5), W'(13), W'(9), s);
    chk("restart_starts", W'(s), W'(258));

    chk("protocol_viol", W'(viol), W'(0));
    chk("queue_empty", W'(q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
